// File: rtl/angle_reduce_arbiter_pkg.sv
// Shared constants, state encoding and quadrant decode for the angle
// range-reduction arbiter.
package angle_reduce_arbiter_pkg;

    localparam int DATA_WIDTH_DEF = 64;
    localparam int ANGLE_MOD      = 360;
    localparam int QUAD_B1        = 90;
    localparam int QUAD_B2        = 180;
    localparam int QUAD_B3        = 270;
    localparam int REM_W          = 9;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_REDUCE = 2'd1,
        ST_RESP   = 2'd2
    } state_e;

    function automatic logic [1:0] quadrant_of(input logic [REM_W-1:0] r);
        if (r < REM_W'(QUAD_B1))      return 2'd0;
        else if (r < REM_W'(QUAD_B2)) return 2'd1;
        else if (r < REM_W'(QUAD_B3)) return 2'd2;
        else                          return 2'd3;
    endfunction

endpackage

// File: rtl/angle_reduce_arbiter_mod360_serial.sv
// Bit-serial modulo-360 remainder: one operand bit per cycle, MSB first.
// remainder/done are combinational so the caller can capture the final value on the last step.
module mod360_serial
    import angle_reduce_arbiter_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] operand,
    output logic                  done,
    output logic [REM_W-1:0]      remainder
);

    localparam int CNT_W = $clog2(DATA_WIDTH);

    logic [DATA_WIDTH-1:0] operand_q, operand_d;
    logic [REM_W-1:0]      rem_q, rem_d;
    logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
    logic                  active_q, active_d;
    logic [REM_W:0]        r_next;
    logic [REM_W-1:0]      r_step;

    // r_next < 720 always, so a single conditional subtract keeps r in 0..359
    always_comb begin
        r_next = {rem_q, operand_q[bit_cnt_q]};
        if (r_next >= (REM_W+1)'(ANGLE_MOD)) begin
            r_step = REM_W'(r_next - (REM_W+1)'(ANGLE_MOD));
        end else begin
            r_step = r_next[REM_W-1:0];
        end
    end

    always_comb begin
        operand_d = operand_q;
        rem_d     = rem_q;
        bit_cnt_d = bit_cnt_q;
        active_d  = active_q;
        if (start) begin
            operand_d = operand;
            rem_d     = '0;
            bit_cnt_d = CNT_W'(DATA_WIDTH - 1);
            active_d  = 1'b1;
        end else if (active_q) begin
            rem_d = r_step;
            if (bit_cnt_q == '0) begin
                active_d = 1'b0;
            end else begin
                bit_cnt_d = bit_cnt_q - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            operand_q <= '0;
            rem_q     <= '0;
            bit_cnt_q <= '0;
            active_q  <= 1'b0;
        end else begin
            operand_q <= operand_d;
            rem_q     <= rem_d;
            bit_cnt_q <= bit_cnt_d;
            active_q  <= active_d;
        end
    end

    assign done      = active_q && (bit_cnt_q == '0);
    assign remainder = r_step;

endmodule

// File: rtl/angle_reduce_arbiter.sv
// Round-robin arbiter sharing one serial mod-360 reducer among trig requesters;
// returns the reduced angle and quadrant tagged with the requester index.
//
// state     | meaning
// ----------+----------------------------------------------------------
// ST_IDLE   | arbitrating; req_ready asserted for the round-robin winner
// ST_REDUCE | serial reduction in progress, requests held off
// ST_RESP   | result presented on rsp_*, waiting for rsp_ready
module angle_reduce_arbiter
    import angle_reduce_arbiter_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int NUM_REQ    = 3,
    parameter int ID_W       = 2
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_angle,
    output logic                          rsp_valid,
    input  logic                          rsp_ready,
    output logic [ID_W-1:0]               rsp_id,
    output logic [DATA_WIDTH-1:0]         rsp_angle,
    output logic [1:0]                    rsp_quadrant,
    output logic                          busy
);

    state_e                state_q, state_d;
    logic [ID_W-1:0]       rr_ptr_q, rr_ptr_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [ID_W-1:0]       rsp_id_q, rsp_id_d;
    logic [DATA_WIDTH-1:0] rsp_angle_q, rsp_angle_d;
    logic [1:0]            rsp_quadrant_q, rsp_quadrant_d;

    logic                  grant_found;
    logic [ID_W-1:0]       grant_idx;
    logic [ID_W-1:0]       cand_idx;
    logic [DATA_WIDTH-1:0] operand_mux;
    logic                  accept;
    logic                  red_done;
    logic [REM_W-1:0]      red_rem;

    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand_idx    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand_idx = ID_W'((int'(rr_ptr_q) + i) % NUM_REQ);
            if (!grant_found && req_valid[cand_idx]) begin
                grant_found = 1'b1;
                grant_idx   = cand_idx;
            end
        end
    end

    always_comb begin
        operand_mux = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_idx == ID_W'(i)) begin
                operand_mux = req_angle[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Ready depends only on state and req_valid, never on rsp_ready
    assign req_ready = (reset_n && (state_q == ST_IDLE) && grant_found)
                       ? (NUM_REQ'(1) << grant_idx) : '0;
    assign accept    = |(req_valid & req_ready);

    mod360_serial #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_mod360 (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (accept),
        .operand   (operand_mux),
        .done      (red_done),
        .remainder (red_rem)
    );

    always_comb begin
        state_d        = state_q;
        rr_ptr_d       = rr_ptr_q;
        rsp_valid_d    = rsp_valid_q;
        rsp_id_d       = rsp_id_q;
        rsp_angle_d    = rsp_angle_q;
        rsp_quadrant_d = rsp_quadrant_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    rsp_id_d = grant_idx;
                    rr_ptr_d = ID_W'((int'(grant_idx) + 1) % NUM_REQ);
                    state_d  = ST_REDUCE;
                end
            end
            ST_REDUCE: begin
                if (red_done) begin
                    rsp_angle_d    = DATA_WIDTH'(red_rem);
                    rsp_quadrant_d = quadrant_of(red_rem);
                    rsp_valid_d    = 1'b1;
                    state_d        = ST_RESP;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                rsp_valid_d = 1'b0;
                state_d     = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q        <= ST_IDLE;
            rr_ptr_q       <= '0;
            rsp_valid_q    <= 1'b0;
            rsp_id_q       <= '0;
            rsp_angle_q    <= '0;
            rsp_quadrant_q <= '0;
        end else begin
            state_q        <= state_d;
            rr_ptr_q       <= rr_ptr_d;
            rsp_valid_q    <= rsp_valid_d;
            rsp_id_q       <= rsp_id_d;
            rsp_angle_q    <= rsp_angle_d;
            rsp_quadrant_q <= rsp_quadrant_d;
        end
    end

    assign rsp_valid    = rsp_valid_q;
    assign rsp_id       = rsp_id_q;
    assign rsp_angle    = rsp_angle_q;
    assign rsp_quadrant = rsp_quadrant_q;
    assign busy         = (state_q != ST_IDLE);

endmodule

// File: tb/tb_angle_reduce_arbiter.sv
// Scoreboard bench for angle_reduce_arbiter: grants push expected results,
// an independent monitor pops and compares on every response handshake.
module tb_angle_reduce_arbiter;

    localparam int DW = 64;
    localparam int NR = 3;
    localparam int IW = 2;

    logic              clk = 1'b0;
    logic              reset_n;
    logic [NR-1:0]     req_valid;
    logic [NR-1:0]     req_ready;
    logic [NR*DW-1:0]  req_angle;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [IW-1:0]     rsp_id;
    logic [DW-1:0]     rsp_angle;
    logic [1:0]        rsp_quadrant;
    logic              busy;

    typedef struct {
        int          id;
        logic [63:0] ang;
        logic [1:0]  q;
        int          acc_cyc;
    } exp_t;

    exp_t        sb_q[$];
    int          grant_log[$];
    int          grant_cnt[NR];
    logic [63:0] exp_ang[NR];
    logic [1:0]  exp_q[NR];
    int          cyc = 0;
    int          errors = 0;
    int          checks = 0;
    int          rsp_count = 0;
    int          rise_cyc = 0;
    logic        prev_v = 1'b0;
    int          wg;

    angle_reduce_arbiter #(
        .DATA_WIDTH (DW),
        .NUM_REQ    (NR),
        .ID_W       (IW)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_angle    (req_angle),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_id       (rsp_id),
        .rsp_angle    (rsp_angle),
        .rsp_quadrant (rsp_quadrant),
        .busy         (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp_v, $time);
        end
    endtask

    // Grant watcher: every handshake pushes the expected response
    always @(negedge clk) begin
        if (reset_n && req_ready != '0) begin
            check("ready_onehot", 64'($onehot(req_ready)), 64'd1);
            check("ready_spurious", 64'(req_ready & ~req_valid), 64'd0);
            check("ready_while_busy", 64'(busy), 64'd0);
            if ((req_valid & req_ready) != '0) begin
                wg = 0;
                for (int i = 0; i < NR; i++) if (req_ready[i]) wg = i;
                sb_q.push_back('{wg, exp_ang[wg], exp_q[wg], cyc});
                grant_log.push_back(wg);
                grant_cnt[wg]++;
            end
        end
    end

    // Response monitor
    always @(negedge clk) begin
        if (!reset_n) begin
            prev_v = 1'b0;
        end else begin
            if (rsp_valid && !prev_v) rise_cyc = cyc;
            prev_v = rsp_valid;
            if (rsp_valid && rsp_ready) begin
                rsp_count++;
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rsp_unexpected: got id %0d angle %0d, required no response", rsp_id, rsp_angle);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    check("rsp_id", 64'(rsp_id), 64'(e.id));
                    check("rsp_angle", rsp_angle, e.ang);
                    check("rsp_quadrant", 64'(rsp_quadrant), 64'(e.q));
                    check("rsp_latency", 64'(rise_cyc - (e.acc_cyc + 1)), 64'(DW));
                end
            end
        end
    end

    task automatic set_req(input int id, input logic [63:0] ang, input logic [63:0] ea, input logic [1:0] eq);
        exp_ang[id] = ea;
        exp_q[id]   = eq;
        req_angle[id*DW +: DW] = ang;
        req_valid[id] = 1'b1;
    endtask

    task automatic send(input int id, input logic [63:0] ang, input logic [63:0] ea,
                        input logic [1:0] eq, output int waited);
        int n0;
        n0 = grant_cnt[id];
        waited = -1;
        @(posedge clk); #1;
        set_req(id, ang, ea, eq);
        for (int k = 0; k < 400; k++) begin
            @(negedge clk); #1;
            if (grant_cnt[id] != n0) begin
                waited = k;
                break;
            end
        end
        check("grant_wait", 64'(grant_cnt[id] != n0), 64'd1);
        @(posedge clk); #1;
        req_valid[id] = 1'b0;
    endtask

    task automatic hold_until(input int n0, input int n1, input int n2);
        int base[NR];
        int need[NR];
        logic all_done;
        need = '{n0, n1, n2};
        for (int i = 0; i < NR; i++) base[i] = grant_cnt[i];
        all_done = 1'b0;
        for (int k = 0; k < 2000 && !all_done; k++) begin
            @(posedge clk); #1;
            all_done = 1'b1;
            for (int i = 0; i < NR; i++) begin
                if (grant_cnt[i] - base[i] >= need[i]) req_valid[i] = 1'b0;
                else all_done = 1'b0;
            end
        end
        check("hold_grants", 64'(all_done), 64'd1);
    endtask

    task automatic drain();
        for (int k = 0; k < 2000 && sb_q.size() != 0; k++) begin
            @(negedge clk); #1;
        end
        check("drain", 64'(sb_q.size()), 64'd0);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    logic [63:0] bnd_in[6]  = '{64'd0, 64'd360, 64'd269, 64'd270, 64'd1000, 64'hFFFF_FFFF_FFFF_FFFF};
    logic [63:0] bnd_out[6] = '{64'd0, 64'd0,   64'd269, 64'd270, 64'd280,  64'd15};
    logic [1:0]  bnd_q[6]   = '{2'd0,  2'd0,    2'd2,    2'd3,    2'd3,     2'd0};

    initial begin
        int w;
        int base_log;
        int base_rsp;
        int base1;
        reset_n   = 1'b0;
        req_valid = '0;
        req_angle = '0;
        rsp_ready = 1'b1;
        for (int i = 0; i < NR; i++) begin
            grant_cnt[i] = 0;
            exp_ang[i]   = '0;
            exp_q[i]     = '0;
        end

        // Reset state, with a request pending that must not be readied
        req_valid[0] = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_req_ready", 64'(req_ready), 64'd0);
        check("rst_rsp_id", 64'(rsp_id), 64'd0);
        check("rst_rsp_angle", rsp_angle, 64'd0);
        check("rst_rsp_quadrant", 64'(rsp_quadrant), 64'd0);
        @(posedge clk); #1;
        req_valid = '0;
        reset_n   = 1'b1;

        // Basic: 725 -> 5, q0, ready in the same cycle
        send(0, 64'd725, 64'd5, 2'd0, w);
        check("t1_same_cycle_ready", 64'(w), 64'd0);
        drain();

        // Boundary values
        for (int i = 0; i < 6; i++) begin
            send(i % NR, bnd_in[i], bnd_out[i], bnd_q[i], w);
        end
        drain();

        // All requesters held from reset: grants 0,1,2,0
        @(posedge clk); #1;
        reset_n = 1'b0;
        set_req(0, 64'd400, 64'd40, 2'd0);
        set_req(1, 64'd100, 64'd100, 2'd1);
        set_req(2, 64'd550, 64'd190, 2'd2);
        base_log = grant_log.size();
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        hold_until(2, 1, 1);
        check("rr_count", 64'(grant_log.size() - base_log), 64'd4);
        if (grant_log.size() - base_log == 4) begin
            check("rr_order0", 64'(grant_log[base_log]),   64'd0);
            check("rr_order1", 64'(grant_log[base_log+1]), 64'd1);
            check("rr_order2", 64'(grant_log[base_log+2]), 64'd2);
            check("rr_order3", 64'(grant_log[base_log+3]), 64'd0);
        end
        drain();

        // Backpressure in RESP with another requester pending
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        send(1, 64'd1000, 64'd280, 2'd3, w);
        set_req(2, 64'd90, 64'd90, 2'd1);
        for (int k = 0; k < 200 && !rsp_valid; k++) begin
            @(negedge clk); #1;
        end
        check("hold_reached", 64'(rsp_valid), 64'd1);
        base_rsp = rsp_count;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check("hold_rsp_valid", 64'(rsp_valid), 64'd1);
            check("hold_rsp_id", 64'(rsp_id), 64'd1);
            check("hold_rsp_angle", rsp_angle, 64'd280);
            check("hold_rsp_quadrant", 64'(rsp_quadrant), 64'd3);
            check("hold_req_ready", 64'(req_ready), 64'd0);
            check("hold_busy", 64'(busy), 64'd1);
        end
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        hold_until(0, 0, 1);
        drain();
        check("hold_rsp_count", 64'(rsp_count - base_rsp), 64'd2);

        // Reset mid-REDUCE: lost request, pointer back to 0
        send(0, 64'd45, 64'd45, 2'd0, w);
        drain();
        send(1, 64'd500, 64'd140, 2'd1, w);
        repeat (20) @(posedge clk);
        #1;
        reset_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("midrst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("midrst_busy", 64'(busy), 64'd0);
        sb_q.delete();
        @(posedge clk); #1;
        reset_n = 1'b1;
        base_log = grant_log.size();
        set_req(0, 64'd720, 64'd0, 2'd0);
        set_req(1, 64'd361, 64'd1, 2'd0);
        set_req(2, 64'd359, 64'd359, 2'd3);
        hold_until(1, 1, 1);
        if (grant_log.size() > base_log) begin
            check("midrst_first_grant", 64'(grant_log[base_log]), 64'd0);
        end else begin
            check("midrst_first_grant", 64'd99, 64'd0);
        end
        drain();

        // Requester 1 withdraws while 2 is pending
        send(0, 64'd180, 64'd180, 2'd2, w);
        base1 = grant_cnt[1];
        base_log = grant_log.size();
        set_req(1, 64'd271, 64'd271, 2'd3);
        set_req(2, 64'd89, 64'd89, 2'd0);
        repeat (10) @(posedge clk);
        #1;
        req_valid[1] = 1'b0;
        hold_until(0, 0, 1);
        check("drop_grant_count1", 64'(grant_cnt[1] - base1), 64'd0);
        if (grant_log.size() > base_log) begin
            check("drop_next_grant", 64'(grant_log[base_log]), 64'd2);
        end else begin
            check("drop_next_grant", 64'd99, 64'd2);
        end
        drain();

        repeat (5) @(posedge clk);
        check("final_queue_empty", 64'(sb_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        errors++;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "watchdog");
    end

endmodule
